perip_pwm_multi: RTL
====================

Name: perip_pwm_multi

Overview:
Memory-mapped multi-channel PWM peripheral on the CPU bus. It is the parametrised successor of the single-channel LED PWM block. NCH channels share one programmable period counter; each channel has its own duty and polarity. Duty and period writes go to shadow registers and take effect only at a period boundary, so outputs never glitch. Typical uses are LED dimming and simple DAC/tone drive in the synth SoC.

Parameters:
NCH, 4, number of PWM channels (1..8)
CNT_W, 16, counter/period/duty width in bits (1..16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
d_in  input  32  bus write data
cs  input  1  peripheral chip select
addr  input  32  bus address; only addr[7:0] decoded
rd  input  1  read strobe
wr  input  1  write strobe
d_out  output  32  registered read data
pwm  output  NCH  PWM outputs, bit i = channel i
irq  output  1  period-wrap interrupt (see Optional Feature)

Behaviour:
- Reset: one clock, synchronous, active-high. All registers clear; d_out=0, pwm=0, irq=0, counter=0.
- Register map (byte offsets, addr[7:0]):
  - 0x00 CTRL: [0] EN.
  - 0x04 PERIOD: shadow, [CNT_W-1:0].
  - 0x08 POL: [NCH-1:0], immediate effect.
  - 0x0C STATUS: [0] WRAP sticky, write-1-to-clear; [31:16] live counter, read-only, zero-extended.
  - 0x20+4*i DUTY[i]: shadow, i<NCH.
- Unmapped or out-of-range offsets: writes ignored, reads return 0. Unused high bits read 0.
- Write: takes effect when cs&&wr at the clock edge.
- Read: when cs&&rd, d_out holds the value on the next cycle (1-cycle latency). Otherwise d_out=0 the next cycle. Simultaneous rd and wr to the same register returns the old value.
- Counter:
  - EN=0: counter held at 0; active period/duty continuously copied from shadows.
  - EN=1: counter increments each clk. When counter==period_active it wraps to 0 on the next edge.
  - Period length = period_active+1 cycles. PERIOD=0 gives a 1-cycle period.
- Boundary load: on the edge where the counter wraps, period_active and duty_active[i] load from their shadows, and WRAP is set.
- Shadow write in the same cycle as a wrap: the load takes the old shadow; the new value applies at the following wrap.
- WRAP set and W1C in the same cycle: set wins.
- Output: raw[i] = EN && (counter < duty_active[i]); pwm[i] = raw[i] XOR POL[i], registered (1-cycle delay from counter).
  - duty 0: raw always 0.
  - duty > period_active: raw always 1 (100%).
  - EN=0: pwm[i] = POL[i] (idle level).
- Enable transition: EN 0→1 starts a fresh period at counter 0 with the shadows already loaded. EN 1→0 forces idle on the next pwm update; the counter is cleared.
- Reset asserted mid-period: everything returns to reset state on that edge; no partial period completes.
- Arithmetic: unsigned compare, CNT_W bits. Bus writes truncate d_in to field width.

Optional Feature:
Macro PWM_MULTI_IRQ_EN.
- Defined: adds register 0x10 IRQ_EN [0]. irq = WRAP && IRQ_EN, registered, so irq rises 1 cycle after WRAP sets and stays high until WRAP is cleared by W1C or IRQ_EN is cleared.
- Not defined: offset 0x10 is unmapped (reads 0), irq tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then read all registers → every read returns 0; pwm=0, irq=0.
- PERIOD=9, DUTY0=3, EN=1 → pwm[0] high exactly 3 of every 10 cycles, period 10 cycles, WRAP set after the first wrap; STATUS reads 1, then write 1 → 0.
- Mid-period write DUTY0=7 → current period keeps 3-cycle high time; next period is 7 high / 3 low; no runt pulse.
- DUTY1=0, DUTY2=15 with PERIOD=9, POL=0b0010 → pwm[1] constant 1 (inverted 0%), pwm[2] constant 1; EN=0 → pwm = POL = 0b0010.
- Write DUTY0=5 on the exact wrap cycle → next period still uses old duty; period after uses 5.
- With PWM_MULTI_IRQ_EN, IRQ_EN=1, PERIOD=4 → irq rises 1 cycle after first wrap, holds until STATUS W1C; reset mid-period → irq=0, pwm=0 next cycle.

Source files
------------

// File: rtl/perip_pwm_multi.sv
// rtl/perip_pwm_multi.sv - multi-channel PWM peripheral with shared period counter and shadowed duty/period
// Optional build macro: PWM_MULTI_IRQ_EN adds IRQ_EN register at 0x10 and drives irq from WRAP.
module perip_pwm_multi #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      d_in,
    input  logic             cs,
    input  logic [31:0]      addr,
    input  logic             rd,
    input  logic             wr,
    output logic [31:0]      d_out,
    output logic [NCH-1:0]   pwm,
    output logic             irq
);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_PERIOD = 8'h04;
    localparam logic [7:0] OFF_POL    = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
`ifdef PWM_MULTI_IRQ_EN
    localparam logic [7:0] OFF_IRQEN  = 8'h10;
`endif

    logic                r_en;
    logic [CNT_W-1:0]    r_period_sh;
    logic [CNT_W-1:0]    r_period_act;
    logic [NCH-1:0]      r_pol;
    logic                r_wrap;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_duty_sh  [NCH];
    logic [CNT_W-1:0]    r_duty_act [NCH];
    logic [NCH-1:0]      r_pwm;
    logic [31:0]         r_dout;

    logic [7:0]          w_off;
    logic                w_we;
    logic                w_re;
    logic                w_duty_ok;
    logic                w_wrap;
    logic [31:0]         w_rdata;
    logic [NCH-1:0]      w_raw;
    logic                w_unused;

    assign w_off = addr[7:0];
    assign w_we  = cs && wr;
    assign w_re  = cs && rd;

    // DUTY window is 0x20..0x3C, word aligned, and only indices below NCH exist.
    assign w_duty_ok = (w_off[7:5] == 3'b001) && (w_off[1:0] == 2'b00) &&
                       ({29'd0, w_off[4:2]} < 32'(NCH));

    // A wrap happens on the edge where the running counter sits at the active period.
    assign w_wrap = r_en && (r_cnt == r_period_act);

    assign w_unused = &{1'b0, addr[31:8], d_in};

    // Bus-writable registers: control, shadows and polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en        <= 1'b0;
            r_period_sh <= '0;
            r_pol       <= '0;
            for (int i = 0; i < NCH; i++) r_duty_sh[i] <= '0;
        end else if (w_we) begin
            if (w_off == OFF_CTRL)   r_en        <= d_in[0];
            if (w_off == OFF_PERIOD) r_period_sh <= d_in[CNT_W-1:0];
            if (w_off == OFF_POL)    r_pol       <= d_in[NCH-1:0];
            for (int i = 0; i < NCH; i++) begin
                if (w_duty_ok && (w_off[4:2] == 3'(i))) r_duty_sh[i] <= d_in[CNT_W-1:0];
            end
        end
    end

    // Period counter; active period/duty follow shadows while idle and reload only at a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_period_act <= '0;
            for (int i = 0; i < NCH; i++) r_duty_act[i] <= '0;
        end else if (!r_en || w_wrap) begin
            r_cnt        <= '0;
            r_period_act <= r_period_sh;
            for (int i = 0; i < NCH; i++) r_duty_act[i] <= r_duty_sh[i];
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sticky WRAP flag; a wrap in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else if (w_wrap) begin
            r_wrap <= 1'b1;
        end else if (w_we && (w_off == OFF_STATUS) && d_in[0]) begin
            r_wrap <= 1'b0;
        end
    end

    // Raw compare per channel; unsigned so duty above the period gives a full-on output.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < NCH; i++) begin
            w_raw[i] = r_en && (r_cnt < r_duty_act[i]);
        end
    end

    // Registered PWM outputs with polarity applied; idle level is POL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_raw ^ r_pol;
        end
    end

`ifdef PWM_MULTI_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // IRQ enable register and registered interrupt level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_we && (w_off == OFF_IRQEN)) r_irq_en <= d_in[0];
            r_irq <= r_wrap && r_irq_en;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Read data mux; anything not decoded reads as zero.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:   w_rdata[0]           = r_en;
            OFF_PERIOD: w_rdata[CNT_W-1:0]   = r_period_sh;
            OFF_POL:    w_rdata[NCH-1:0]     = r_pol;
            OFF_STATUS: begin
                w_rdata[0]          = r_wrap;
                w_rdata[16 +: CNT_W] = r_cnt;
            end
`ifdef PWM_MULTI_IRQ_EN
            OFF_IRQEN:  w_rdata[0]           = r_irq_en;
`endif
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (w_duty_ok && (w_off[4:2] == 3'(i))) w_rdata[CNT_W-1:0] = r_duty_sh[i];
                end
            end
        endcase
    end

    // Read port with one-cycle latency; returns zero when no read is strobed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_re ? w_rdata : 32'd0;
        end
    end

    assign d_out = r_dout;
    assign pwm   = r_pwm;

endmodule
